// File: rtl/rom_loader_pkg.sv
// Shared constants for the ROM loader: FSM state encoding and sector geometry.
package rom_loader_pkg;

  localparam int unsigned SECTOR_BYTES = 512;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] RECV    = 3'd2;
  localparam logic [2:0] WAITEND = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

endpackage

// File: rtl/rom_loader.sv
// ROM loader: on a load request, reads a slot's sector range from the SD block-read
// controller and writes the byte stream sequentially into cartridge RAM while holding
// the console CPU in reset.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_SECTOR    = 32'd0,
  parameter int unsigned ROM_SECTORS    = 16,
  parameter int unsigned ADDR_W         = 13,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              do_load_rom,
  input  logic [15:0]       selected_rom,
  output logic              sd_rd_req,
  output logic [31:0]       sd_sector,
  input  logic              sd_busy,
  input  logic              sd_byte_valid,
  input  logic [7:0]        sd_byte,
  input  logic              sd_error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              hold_reset,
  output logic              loading,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [15:0] LastSector  = 16'(ROM_SECTORS - 1);
  localparam logic [9:0]  LastByteCnt = 10'(SECTOR_BYTES - 1);

  logic [2:0]        state_q, state_d;
  logic              do_load_q;
  logic              load_edge;
  logic [31:0]       sector_q, sector_d;
  logic [15:0]       sector_cnt_q, sector_cnt_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       wd_q, wd_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  assign load_edge = do_load_rom & ~do_load_q;

  // Next-state logic: FSM sequencing, counters, watchdog and RAM write port.
  always_comb begin
    state_d      = state_q;
    sector_d     = sector_q;
    sector_cnt_d = sector_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    hold_d       = hold_q;
    err_d        = err_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    done_d       = 1'b0;
    // Watchdog counts down by default; reloads below override this.
    wd_d         = (wd_q != 24'd0) ? wd_q - 24'd1 : 24'd0;

    case (state_q)
      IDLE: begin
        if (load_edge) begin
          sector_d     = BASE_SECTOR + {16'd0, selected_rom} * 32'(ROM_SECTORS);
          sector_cnt_d = 16'd0;
          byte_cnt_d   = 10'd0;
          err_d        = 1'b0;
          hold_d       = 1'b1;
          wd_d         = TIMEOUT_CYCLES;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (sd_error || wd_q == 24'd0) begin
          state_d = ERR;
        end else if (sd_busy) begin
          state_d = RECV;
        end
      end
      RECV: begin
        // An error wins over a coincident byte strobe: nothing is written.
        if (sd_error || wd_q == 24'd0) begin
          state_d = ERR;
        end else if (sd_byte_valid) begin
          wd_d       = TIMEOUT_CYCLES;
          we_d       = 1'b1;
          addr_d     = ADDR_W'({sector_cnt_q, byte_cnt_q[8:0]});
          data_d     = sd_byte;
          byte_cnt_d = byte_cnt_q + 10'd1;
          if (byte_cnt_q == LastByteCnt) begin
            state_d = WAITEND;
          end
        end
      end
      WAITEND: begin
        if (sd_error) begin
          state_d = ERR;
        end else if (!sd_busy) begin
          if (sector_cnt_q == LastSector) begin
            state_d = DONE;
          end else begin
            sector_cnt_d = sector_cnt_q + 16'd1;
            sector_d     = sector_q + 32'd1;
            byte_cnt_d   = 10'd0;
            wd_d         = TIMEOUT_CYCLES;
            state_d      = REQ;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      do_load_q    <= 1'b0;
      sector_q     <= 32'd0;
      sector_cnt_q <= 16'd0;
      byte_cnt_q   <= 10'd0;
      wd_q         <= 24'd0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      do_load_q    <= do_load_rom;
      sector_q     <= sector_d;
      sector_cnt_q <= sector_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      wd_q         <= wd_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign sd_rd_req  = (state_q == REQ);
  assign sd_sector  = sector_q;
  assign loading    = (state_q != IDLE);
  assign hold_reset = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: an SD controller model streams sectors, a RAM
// model captures writes, and expected RAM contents come from slot/sector arithmetic.
module tb_rom_loader;

  localparam int unsigned RS    = 2;
  localparam logic [31:0] BASE  = 32'd100;
  localparam int unsigned AW    = 10;
  localparam logic [23:0] TO    = 24'd100;
  localparam int          TOTAL = RS * 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          do_load_rom = 1'b0;
  logic [15:0]   selected_rom = 16'd0;
  logic          sd_rd_req;
  logic [31:0]   sd_sector;
  logic          sd_busy = 1'b0;
  logic          sd_byte_valid = 1'b0;
  logic [7:0]    sd_byte = 8'd0;
  logic          sd_error = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          hold_reset;
  logic          loading;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  rom_loader #(
    .BASE_SECTOR   (BASE),
    .ROM_SECTORS   (RS),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .do_load_rom  (do_load_rom),
    .selected_rom (selected_rom),
    .sd_rd_req    (sd_rd_req),
    .sd_sector    (sd_sector),
    .sd_busy      (sd_busy),
    .sd_byte_valid(sd_byte_valid),
    .sd_byte      (sd_byte),
    .sd_error     (sd_error),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .hold_reset   (hold_reset),
    .loading      (loading),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] ram     [0:TOTAL-1];
  logic [7:0] exp_ram [0:TOTAL-1];
  int wr_cnt   = 0;
  int done_cnt = 0;
  int max_addr = 0;

  // Cartridge RAM model and event counters.
  always @(negedge clk) begin
    if (mem_we) begin
      ram[mem_addr] = mem_data;
      wr_cnt++;
      if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end
    if (load_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {sd_rd_req, sd_sector, mem_we, mem_addr, mem_data, hold_reset, loading,
                load_done, load_error}, 64'd0);
  endtask

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < TOTAL; i++) if (ram[i] !== exp_ram[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic start_load(input logic [15:0] rom, input int hold);
    selected_rom = rom;
    do_load_rom  = 1'b1;
    tick();
    check("start_req", sd_rd_req, 1);
    check("start_hold", hold_reset, 1);
    check("start_loading", loading, 1);
    check("start_err_clear", load_error, 0);
    repeat (hold - 1) tick();
    do_load_rom = 1'b0;
  endtask

  // Serves one sector; negative indices disable the error, re-pulse and abort hooks.
  task automatic serve_sector(input logic [15:0] rom, input int sec, input int nbytes,
                              input int err_at, input int repulse_at, input int abort_at,
                              input bit pattern);
    bit ok = 1'b0;
    int addr;
    logic [7:0] b;
    logic [31:0] exp_sec;
    for (int i = 0; i < 60; i++) begin
      if (sd_rd_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("req_seen", ok, 1);
    if (!ok) return;
    exp_sec = BASE + {16'd0, rom} * 32'(RS) + 32'(sec);
    check("sd_sector", sd_sector, exp_sec);
    sd_busy = 1'b1;
    tick();
    check("req_drop", sd_rd_req, 0);
    for (int i = 0; i < nbytes; i++) begin
      if (i == abort_at) return;
      if (i == repulse_at) do_load_rom = 1'b1;
      if (i == repulse_at + 3) do_load_rom = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      addr = sec * 512 + i;
      b = pattern ? 8'(addr) : 8'($urandom);
      sd_byte = b;
      sd_byte_valid = 1'b1;
      if (i == err_at) sd_error = 1'b1;
      else if (i < 512) exp_ram[addr] = b;
      tick();
      sd_byte_valid = 1'b0;
      sd_error = 1'b0;
      if (i == err_at) return;
      if (i == 0) begin
        check("first_we", mem_we, 1);
        check("first_addr", mem_addr, 64'(addr));
        check("first_data", mem_data, b);
      end
    end
    sd_busy = 1'b0;
    tick();
  endtask

  task automatic run_load(input logic [15:0] rom, input int hold, input bit pattern,
                          input int repulse_at, input int extra0);
    int w0;
    int d0;
    bit ok = 1'b0;
    w0 = wr_cnt;
    d0 = done_cnt;
    max_addr = 0;
    start_load(rom, hold);
    serve_sector(rom, 0, 512 + extra0, -1, repulse_at, -1, pattern);
    check("s0_writes", wr_cnt - w0, 512);
    check("s0_max_addr", max_addr, 511);
    for (int s = 1; s < RS; s++) serve_sector(rom, s, 512, -1, -1, -1, pattern);
    for (int i = 0; i < 100; i++) begin
      if (load_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", ok, 1);
    check("done_hold_low", hold_reset, 0);
    check("done_err_low", load_error, 0);
    tick();
    check("done_one_cycle", load_done, 0);
    check("idle_after_done", loading, 0);
    repeat (10) tick();
    check("done_count", done_cnt - d0, 1);
    check("load_writes", wr_cnt - w0, TOTAL);
    check("idle_no_req", sd_rd_req, 0);
    check_ram("ram_contents");
  endtask

  initial begin
    int w0;
    int n;
    logic [15:0] rom;

    for (int i = 0; i < TOTAL; i++) exp_ram[i] = 8'd0;

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    tick();
    check_all_zero("idle_outputs");

    // Slot 3, data = low address byte: sectors 106 and 107.
    run_load(16'd3, 1, 1'b1, -1, 0);

    // Long request pulse plus a second edge mid-load: exactly one load.
    run_load(16'($urandom_range(0, 65535)), 9, 1'b0, 100, 0);

    // SD error on byte 200 of sector 0, coincident with a byte strobe.
    rom = 16'($urandom_range(0, 65535));
    w0 = wr_cnt;
    start_load(rom, 1);
    serve_sector(rom, 0, 512, 200, -1, -1, 1'b0);
    sd_busy = 1'b0;
    repeat (2) tick();
    check("err_flag", load_error, 1);
    check("err_hold_low", hold_reset, 0);
    check("err_idle", loading, 0);
    for (int i = 0; i < 5; i++) begin
      sd_byte_valid = 1'b1;
      tick();
      sd_byte_valid = 1'b0;
      tick();
    end
    check("err_writes", wr_cnt - w0, 200);
    check("err_sticky", load_error, 1);
    run_load(16'($urandom_range(0, 65535)), 1, 1'b0, -1, 0);

    // SD controller never acknowledges: watchdog expires in REQ.
    start_load(16'($urandom_range(0, 65535)), 1);
    n = 0;
    while (!load_error && n < 300) begin
      tick();
      n++;
    end
    check("timeout_err", load_error, 1);
    check("timeout_window", (n >= 95 && n <= 110), 1);
    check("timeout_hold_low", hold_reset, 0);

    // 520 strobes in sector 0: only 512 written.
    run_load(16'($urandom_range(0, 65535)), 1, 1'b0, -1, 8);

    // Reset during RECV, then a normal load.
    rom = 16'($urandom_range(0, 65535));
    start_load(rom, 1);
    serve_sector(rom, 0, 512, -1, -1, 50, 1'b0);
    sd_busy = 1'b0;
    reset = 1'b1;
    tick();
    check_all_zero("midload_reset_outputs");
    reset = 1'b0;
    tick();
    check("midload_reset_idle", loading, 0);
    run_load(16'($urandom_range(0, 65535)), 1, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Responder side of the OSD ROM-select interface. It detects a load request and its 16-bit ROM slot number, then reads that slot's fixed-size sector range from the SD block-read controller. The byte stream is written sequentially into cartridge RAM, and the console CPU is held in reset for the whole transfer. It sits between the OSD, the SD controller and the cartridge RAM port.

## Interface
Parameters:
- BASE_SECTOR, 32'd0, first SD sector of slot 0
- ROM_SECTORS, 16, sectors per slot; power of two, ≥1
- ADDR_W, 13, cartridge RAM address width; must equal log2(ROM_SECTORS*512)
- TIMEOUT_CYCLES, 24'hFFFFFF, maximum wait for an SD acknowledge or a byte

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- do_load_rom  in  1  load request; a multi-cycle pulse, acted on at its rising edge
- selected_rom  in  16  slot number; valid at the rising edge of do_load_rom
- sd_rd_req  out  1  sector read request
- sd_sector  out  32  sector address; stable while sd_rd_req is high
- sd_busy  in  1  SD controller acknowledge/busy
- sd_byte_valid  in  1  one-cycle strobe: sd_byte carries a data byte
- sd_byte  in  8  read data
- sd_error  in  1  SD controller error flag
- mem_we  out  1  cartridge RAM write strobe
- mem_addr  out  ADDR_W  cartridge RAM write address
- mem_data  out  8  cartridge RAM write data
- hold_reset  out  1  holds the console CPU in reset while loading
- loading  out  1  high in any non-IDLE state
- load_done  out  1  one-cycle pulse when a load completes successfully
- load_error  out  1  sticky error flag; cleared by the next request or by reset

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0.
- Rising-edge detector on do_load_rom uses a registered previous value. Only an edge seen in IDLE starts a load. Edges in any other state are ignored.
- Start address: sd_sector = BASE_SECTOR + selected_rom*ROM_SECTORS. Computed and latched in 32-bit arithmetic when the edge is accepted; wraps modulo 2^32.
- States:
  - IDLE: on an accepted edge, latch the start sector, clear sector_cnt, byte_cnt and load_error, set hold_reset, go to REQ.
  - REQ: assert sd_rd_req. When sd_busy=1, drop sd_rd_req and go to RECV.
  - RECV:
    - Each sd_byte_valid writes one byte and increments byte_cnt (10 bits).
    - After byte 512, go to WAITEND. Any further sd_byte_valid in this sector is ignored (no write).
  - WAITEND:
    - When sd_busy=0:
      - If sector_cnt = ROM_SECTORS-1, go to DONE.
      - Otherwise increment sector_cnt and sd_sector, clear byte_cnt, go to REQ.
  - DONE: pulse load_done, clear hold_reset, go to IDLE.
  - ERR: set load_error, clear hold_reset, go to IDLE.
- Errors:
  - sd_error=1 in REQ, RECV or WAITEND sends the block to ERR.
  - A watchdog reloads on entry to REQ and on every sd_byte_valid and decrements otherwise. Reaching 0 in REQ or RECV sends the block to ERR.
- RAM address: mem_addr = {sector_cnt, byte_cnt[8:0]}, truncated to ADDR_W. The full slot is written exactly once, addresses ascending from 0.

## Timing
- do_load_rom rises at cycle t (first cycle it samples high): sd_rd_req=1, hold_reset=1 and loading=1 from t+1.
- sd_busy first sampled high at cycle a: sd_rd_req=0 from a+1.
- sd_byte_valid at cycle b: mem_we=1 with mem_addr and mem_data valid at b+1, for exactly one cycle.
- Next sector: REQ is re-entered on the cycle after sd_busy is sampled low in WAITEND.
- Completion: load_done=1 for exactly one cycle, together with hold_reset falling.
- Simultaneous sd_error and sd_byte_valid: the error takes priority and no write occurs.
- Reset mid-load: the block returns to IDLE the next cycle with all outputs 0. RAM contents are left partial.

## Structure
- Package rom_loader_pkg holds:
  - the state enumeration: IDLE, REQ, RECV, WAITEND, DONE, ERR;
  - SECTOR_BYTES = 512.
- A single flat module. No sub-module is needed; the edge detector and watchdog are inline.

## Test plan
- ROM_SECTORS=2, BASE_SECTOR=100, selected_rom=3, model streams 1024 bytes with value addr[7:0] → sd_sector 106 then 107; RAM 0..1023 match; load_done once; hold_reset low afterwards.
- do_load_rom held high for 9 cycles, then pulsed again mid-load → exactly one load; the second edge is ignored.
- sd_error asserted after 200 bytes of sector 0 → ERR; load_error=1; hold_reset=0; no further writes. A new request clears load_error.
- Model never raises sd_busy, TIMEOUT_CYCLES=100 → load_error after about 100 cycles in REQ.
- 520 bytes strobed in one sector → only 512 writes; mem_addr never exceeds 511 for sector 0.
- reset asserted during RECV → next cycle all outputs 0 and state IDLE; a following request loads normally.
